// File: rtl/fpnew_pipe_out_lanes.sv
`default_nettype none
// ============================================================================
// Module   : fpnew_pipe_out_lanes
// Brief    : Multi-lane output pipeline with one shared valid/ready handshake,
//            per-item tag kill, flush, and per-lane enables for data registers.
// Revision : 1.0 - initial release
// ============================================================================
module fpnew_pipe_out_lanes #(
    parameter int Width       = 32,
    parameter int NumLanes    = 2,
    parameter int NumPipeRegs = 2,
    parameter int TagWidth    = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NumLanes*Width-1:0]     result_i,
    input  logic [NumLanes*5-1:0]         status_i,
    input  logic [NumLanes-1:0]           lane_mask_i,
    input  logic [TagWidth-1:0]           tag_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic                          flush_i,
    input  logic                          kill_i,
    input  logic [TagWidth-1:0]           kill_tag_i,
    input  logic [TagWidth-1:0]           kill_tag_mask_i,
    output logic [NumLanes*Width-1:0]     result_o,
    output logic [NumLanes*5-1:0]         status_o,
    output logic [NumLanes-1:0]           lane_mask_o,
    output logic [TagWidth-1:0]           tag_o,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [((NumPipeRegs > 0) ? $clog2(NumPipeRegs+1) : 1)-1:0] occupancy_o,
    output logic                          busy_o
);

    localparam int c_n     = NumPipeRegs;
    localparam int c_occ_w = (NumPipeRegs > 0) ? $clog2(NumPipeRegs+1) : 1;

    // Stage-indexed views; stage 0 is the raw input, stage c_n feeds the outputs.
    logic [c_n:0]                        w_valid;
    logic [c_n:0]                        w_ready;
    logic [c_n:0]                        w_kill;
    logic [(c_n+1)*TagWidth-1:0]         w_tag_all;
    logic [(c_n+1)*NumLanes-1:0]         w_mask_all;
    logic [(c_n+1)*NumLanes*Width-1:0]   w_res_all;
    logic [(c_n+1)*NumLanes*5-1:0]       w_stat_all;
    logic [c_occ_w-1:0]                  w_occ;

    assign w_valid[0]                         = in_valid_i;
    assign w_kill[0]                          = 1'b0;
    assign w_tag_all[0 +: TagWidth]           = tag_i;
    assign w_mask_all[0 +: NumLanes]          = lane_mask_i;
    assign w_res_all[0 +: NumLanes*Width]     = result_i;
    assign w_stat_all[0 +: NumLanes*5]        = status_i;
    assign w_ready[c_n]                       = out_ready_i;

    // Closed form of ready[i] = ready[i+1] | ~valid[i+1], avoiding a bit-level loop.
    for (genvar i = 0; i < c_n; i++) begin : g_ready
        assign w_ready[i] = out_ready_i | ~(&w_valid[c_n:i+1]);
    end

    for (genvar j = 1; j <= c_n; j++) begin : g_kill
        assign w_kill[j] = kill_i & w_valid[j] &
            (((w_tag_all[j*TagWidth +: TagWidth] ^ kill_tag_i) & kill_tag_mask_i) == '0);
    end

    for (genvar i = 0; i < c_n; i++) begin : g_stage
        logic                r_valid;
        logic [TagWidth-1:0] r_tag;
        logic [NumLanes-1:0] r_mask;
        logic                w_load;

        assign w_load = w_ready[i] & w_valid[i];

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_valid <= 1'b0;
                r_tag   <= '0;
                r_mask  <= '0;
            end else begin
                if (flush_i)
                    r_valid <= 1'b0;
                else if (w_ready[i])
                    r_valid <= w_valid[i] & ~w_kill[i];
                else
                    r_valid <= r_valid & ~w_kill[i+1];
                if (w_load) begin
                    r_tag  <= w_tag_all[i*TagWidth +: TagWidth];
                    r_mask <= w_mask_all[i*NumLanes +: NumLanes];
                end
            end
        end

        assign w_valid[i+1]                           = r_valid;
        assign w_tag_all[(i+1)*TagWidth +: TagWidth]  = r_tag;
        assign w_mask_all[(i+1)*NumLanes +: NumLanes] = r_mask;

        // Inactive lanes keep their old contents so their registers stay gated.
        for (genvar l = 0; l < NumLanes; l++) begin : g_lane
            logic [Width-1:0] r_res;
            logic [4:0]       r_stat;

            always_ff @(posedge clk_i) begin
                if (w_load && w_mask_all[i*NumLanes+l]) begin
                    r_res  <= w_res_all[(i*NumLanes+l)*Width +: Width];
                    r_stat <= w_stat_all[(i*NumLanes+l)*5 +: 5];
                end
            end

            assign w_res_all[((i+1)*NumLanes+l)*Width +: Width] = r_res;
            assign w_stat_all[((i+1)*NumLanes+l)*5 +: 5]        = r_stat;
        end
    end

    for (genvar l = 0; l < NumLanes; l++) begin : g_out
        logic w_on;
        assign w_on = w_mask_all[c_n*NumLanes+l];
        assign result_o[l*Width +: Width] =
            w_on ? w_res_all[(c_n*NumLanes+l)*Width +: Width] : '0;
        assign status_o[l*5 +: 5] =
            w_on ? w_stat_all[(c_n*NumLanes+l)*5 +: 5] : '0;
    end

    always_comb begin
        w_occ = '0;
        for (int j = 1; j <= c_n; j++)
            w_occ = w_occ + c_occ_w'(w_valid[j]);
    end

    assign in_ready_o  = w_ready[0];
    assign out_valid_o = w_valid[c_n] & ~w_kill[c_n];
    assign tag_o       = w_tag_all[c_n*TagWidth +: TagWidth];
    assign lane_mask_o = w_mask_all[c_n*NumLanes +: NumLanes];
    assign occupancy_o = w_occ;
    assign busy_o      = |w_valid;

endmodule
`default_nettype wire
